// File: rtl/fp_div_pkg.sv
// rtl/fp_div_pkg.sv - shared widths, constants, states and flag indices for fp_div_seq
package fp_div_pkg;

  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t DIVIDE = 2'd1;
  localparam state_t ROUND  = 2'd2;
  localparam state_t DONE   = 2'd3;

  localparam int FLAG_INVALID   = 4;
  localparam int FLAG_DIV_ZERO  = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  function automatic int mant_w(input int bw);
    return (bw == 32) ? 23 : 52;
  endfunction

  function automatic int exp_w(input int bw);
    return (bw == 32) ? 8 : 11;
  endfunction

  function automatic int bias_of(input int bw);
    return (bw == 32) ? 127 : 1023;
  endfunction

  // integer bit, MANT fraction bits, guard, round
  function automatic int qbits(input int bw);
    return mant_w(bw) + 3;
  endfunction

  function automatic logic [63:0] qnan(input int bw);
    return (bw == 32) ? 64'h0000_0000_7FC0_0000 : 64'h7FF8_0000_0000_0000;
  endfunction

  function automatic logic [63:0] zero_of(input int bw, input logic sign);
    logic [63:0] r;
    r = '0;
    r[bw-1] = sign;
    return r;
  endfunction

  function automatic logic [63:0] inf_of(input int bw, input logic sign);
    logic [63:0] r;
    r = ((64'd1 << exp_w(bw)) - 64'd1) << mant_w(bw);
    r[bw-1] = sign;
    return r;
  endfunction

endpackage

// File: rtl/fp_div_round.sv
// rtl/fp_div_round.sv - combinational normalise, round-to-nearest-even, range check and pack
module fp_div_round
  import fp_div_pkg::*;
#(
  parameter  int BUS_WIDTH = 64,
  localparam int MW        = mant_w(BUS_WIDTH),
  localparam int EW        = exp_w(BUS_WIDTH),
  localparam int QB        = qbits(BUS_WIDTH)
) (
  input  logic                  sign,
  input  logic signed [EW+1:0]  exp_in,
  input  logic [QB-1:0]         quot,
  input  logic                  sticky,
  output logic [BUS_WIDTH-1:0]  result,
  output logic [4:0]            flags
);

  logic [QB-1:0]        norm;
  logic signed [EW+1:0] exp_n;
  logic signed [EW+1:0] exp_r;
  logic [MW:0]          mant;
  logic [MW+1:0]        sum;
  logic                 guard;
  logic                 rnd;
  logic                 up;
  logic                 inexact;

  always_comb begin
    norm    = quot[QB-1] ? quot : {quot[QB-2:0], 1'b0};
    exp_n   = quot[QB-1] ? exp_in : exp_in - (EW+2)'(1);
    mant    = norm[QB-1:2];
    guard   = norm[1];
    rnd     = norm[0];
    inexact = guard | rnd | sticky;
    up      = guard & (rnd | sticky | mant[0]);
    // a carry out of the mantissa leaves all-zero fraction bits, so only the exponent moves
    sum     = {1'b0, mant} + (MW+2)'(up);
    exp_r   = exp_n + (EW+2)'(sum[MW+1]);

    flags = '0;
    flags[FLAG_INEXACT] = inexact;
    if (exp_r >= (EW+2)'((1 << EW) - 1)) begin
      result = {sign, {EW{1'b1}}, {MW{1'b0}}};
      flags[FLAG_OVERFLOW] = 1'b1;
      flags[FLAG_INEXACT]  = 1'b1;
    end else if (exp_r <= (EW+2)'(0)) begin
      result = {sign, {(BUS_WIDTH-1){1'b0}}};
      flags[FLAG_UNDERFLOW] = 1'b1;
      flags[FLAG_INEXACT]   = 1'b1;
    end else begin
      result = {sign, exp_r[EW-1:0], sum[MW-1:0]};
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// rtl/fp_div_seq.sv - iterative radix-2 restoring IEEE-754 divider with valid/ready handshake
module fp_div_seq
  import fp_div_pkg::*;
#(
  parameter  int BUS_WIDTH = 64,
  localparam int MW        = mant_w(BUS_WIDTH),
  localparam int EW        = exp_w(BUS_WIDTH),
  localparam int QB        = qbits(BUS_WIDTH),
  localparam int CW        = $clog2(QB)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] in1,
  input  logic [BUS_WIDTH-1:0] in2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out,
  output logic [4:0]           flags
);

  state_t               state;
  logic                 sign_q;
  logic signed [EW+1:0] exp_q;
  logic [MW:0]          div_q;
  logic [MW+1:0]        rem_q;
  logic [QB-1:0]        quot_q;
  logic [CW-1:0]        cnt_q;

  logic [EW-1:0]        e1, e2;
  logic [MW-1:0]        f1, f2;
  logic                 zero1, zero2, inf1, inf2, nan1, nan2, sign;
  logic                 spec_hit;
  logic [BUS_WIDTH-1:0] spec_res;
  logic [4:0]           spec_flags;
  logic                 ge;
  logic [MW+1:0]        diff;
  logic [BUS_WIDTH-1:0] rnd_res;
  logic [4:0]           rnd_flags;

  assign e1 = in1[BUS_WIDTH-2 -: EW];
  assign e2 = in2[BUS_WIDTH-2 -: EW];
  assign f1 = in1[MW-1:0];
  assign f2 = in2[MW-1:0];
  // subnormals are flushed: a zero exponent field is treated as zero whatever the fraction
  assign zero1 = (e1 == '0);
  assign zero2 = (e2 == '0);
  assign inf1  = (&e1) && (f1 == '0);
  assign inf2  = (&e2) && (f2 == '0);
  assign nan1  = (&e1) && (f1 != '0);
  assign nan2  = (&e2) && (f2 != '0);
  assign sign  = in1[BUS_WIDTH-1] ^ in2[BUS_WIDTH-1];

  always_comb begin
    spec_hit   = 1'b1;
    spec_res   = '0;
    spec_flags = '0;
    if (nan1 || nan2 || (zero1 && zero2) || (inf1 && inf2)) begin
      spec_res = BUS_WIDTH'(qnan(BUS_WIDTH));
      spec_flags[FLAG_INVALID] = 1'b1;
    end else if (inf1) begin
      spec_res = BUS_WIDTH'(inf_of(BUS_WIDTH, sign));
    end else if (zero2) begin
      spec_res = BUS_WIDTH'(inf_of(BUS_WIDTH, sign));
      spec_flags[FLAG_DIV_ZERO] = 1'b1;
    end else if (zero1 || inf2) begin
      spec_res = BUS_WIDTH'(zero_of(BUS_WIDTH, sign));
    end else begin
      spec_hit = 1'b0;
    end
  end

  // rem < 2*div always holds, so the difference fits in MANT+1 bits before the shift
  assign ge   = (rem_q >= {1'b0, div_q});
  assign diff = ge ? (rem_q - {1'b0, div_q}) : rem_q;

  fp_div_round #(.BUS_WIDTH(BUS_WIDTH)) u_round (
    .sign   (sign_q),
    .exp_in (exp_q),
    .quot   (quot_q),
    .sticky (|rem_q),
    .result (rnd_res),
    .flags  (rnd_flags)
  );

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out       <= '0;
      flags     <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      div_q     <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      cnt_q     <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign_q <= sign;
          exp_q  <= {2'b00, e1} - {2'b00, e2} + (EW+2)'(bias_of(BUS_WIDTH));
          div_q  <= {1'b1, f2};
          rem_q  <= {2'b01, f1};
          quot_q <= '0;
          cnt_q  <= '0;
          if (spec_hit) begin
            out   <= spec_res;
            flags <= spec_flags;
            state <= DONE;
          end else begin
            state <= DIVIDE;
          end
        end
        DIVIDE: begin
          rem_q  <= {diff[MW:0], 1'b0};
          quot_q <= {quot_q[QB-2:0], ge};
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CW'(QB - 1)) state <= ROUND;
        end
        ROUND: begin
          out   <= rnd_res;
          flags <= rnd_flags;
          state <= DONE;
        end
        DONE: begin
          // result registers settle on entry; valid is raised one cycle later
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// tb/tb_fp_div_seq.sv - self-checking bench for fp_div_seq at binary32 and binary64
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        v32_in_valid, v32_in_ready, v32_out_valid, v32_out_ready;
  logic [31:0] a32, b32, o32;
  logic [4:0]  f32;
  logic        v64_in_valid, v64_in_ready, v64_out_valid, v64_out_ready;
  logic [63:0] a64, b64, o64;
  logic [4:0]  f64;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fp_div_seq #(.BUS_WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(v32_in_valid), .in_ready(v32_in_ready),
    .in1(a32), .in2(b32), .out_valid(v32_out_valid), .out_ready(v32_out_ready),
    .out(o32), .flags(f32)
  );

  fp_div_seq #(.BUS_WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(v64_in_valid), .in_ready(v64_in_ready),
    .in1(a64), .in2(b64), .out_valid(v64_out_valid), .out_ready(v64_out_ready),
    .out(o64), .flags(f64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic ov(input int bw);
    return (bw == 32) ? v32_out_valid : v64_out_valid;
  endfunction

  function automatic logic ir(input int bw);
    return (bw == 32) ? v32_in_ready : v64_in_ready;
  endfunction

  function automatic logic [63:0] res(input int bw);
    return (bw == 32) ? {32'b0, o32} : o64;
  endfunction

  function automatic logic [4:0] flg(input int bw);
    return (bw == 32) ? f32 : f64;
  endfunction

  task automatic drive(input int bw, input logic valid, input logic [63:0] a, input logic [63:0] b);
    if (bw == 32) begin
      v32_in_valid = valid; a32 = a[31:0]; b32 = b[31:0];
    end else begin
      v64_in_valid = valid; a64 = a; b64 = b;
    end
  endtask

  task automatic set_ready(input int bw, input logic r);
    if (bw == 32) v32_out_ready = r;
    else          v64_out_ready = r;
  endtask

  // Reference: exact integer quotient with extra bits, then textbook RNE.
  function automatic void model(input int bw, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] r_out, output logic [4:0] fl, output bit special);
    int mw, ew, bias, emax, ea, eb, e, extra;
    logic [63:0] fmask, fa, fb, zero, inf;
    logic [127:0] num, den, q, r, mant, low, half;
    logic s, za, zb, ia, ib, na, nb, inexact, up;
    mw    = (bw == 32) ? 23 : 52;
    ew    = (bw == 32) ? 8 : 11;
    bias  = (bw == 32) ? 127 : 1023;
    emax  = (1 << ew) - 1;
    fmask = (64'd1 << mw) - 64'd1;
    ea = int'((a >> mw) & 64'(emax));
    eb = int'((b >> mw) & 64'(emax));
    fa = a & fmask;
    fb = b & fmask;
    za = (ea == 0); zb = (eb == 0);
    ia = (ea == emax) && (fa == 0); ib = (eb == emax) && (fb == 0);
    na = (ea == emax) && (fa != 0); nb = (eb == emax) && (fb != 0);
    s  = a[bw-1] ^ b[bw-1];
    zero = 64'(s) << (bw - 1);
    inf  = zero | (64'(emax) << mw);
    special = 1'b1;
    fl = 5'b0;
    r_out = 64'b0;
    if (na || nb || (za && zb) || (ia && ib)) begin
      r_out = (bw == 32) ? 64'h7FC00000 : 64'h7FF8000000000000;
      fl = 5'b10000;
    end else if (ia) begin
      r_out = inf;
    end else if (zb) begin
      r_out = inf; fl = 5'b01000;
    end else if (za || ib) begin
      r_out = zero;
    end else begin
      special = 1'b0;
      num = 128'(fa | (64'd1 << mw)) << (mw + 3);
      den = 128'(fb | (64'd1 << mw));
      q = num / den;
      r = num % den;
      e = ea - eb + bias;
      if (q >= (128'd1 << (mw + 3))) extra = 3;
      else begin extra = 2; e = e - 1; end
      mant = q >> extra;
      low  = q & ((128'd1 << extra) - 128'd1);
      half = 128'd1 << (extra - 1);
      inexact = (low != 0) || (r != 0);
      up = (low > half) || ((low == half) && ((r != 0) || mant[0]));
      mant = mant + 128'(up);
      if (mant == (128'd1 << (mw + 1))) begin mant = mant >> 1; e = e + 1; end
      if (e >= emax) begin
        r_out = inf; fl = 5'b00101;
      end else if (e <= 0) begin
        r_out = zero; fl = 5'b00011;
      end else begin
        r_out = zero | (64'(e) << mw) | (mant[63:0] & fmask);
        fl = {4'b0, inexact};
      end
    end
  endfunction

  function automatic logic [63:0] gen(input int bw);
    int mw, ew, bias, emax, sel, e;
    logic [63:0] frac, r;
    mw   = (bw == 32) ? 23 : 52;
    ew   = (bw == 32) ? 8 : 11;
    bias = (bw == 32) ? 127 : 1023;
    emax = (1 << ew) - 1;
    sel  = int'($urandom_range(0, 9));
    frac = {$urandom, $urandom} & ((64'd1 << mw) - 64'd1);
    if (sel < 7)       e = bias + int'($urandom_range(0, 60)) - 30;
    else if (sel == 7) e = int'($urandom_range(0, emax));
    else if (sel == 8) begin
      e = ($urandom_range(0, 1) == 0) ? 0 : emax;
      if ($urandom_range(0, 1) == 0) frac = 64'b0;
    end else e = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 3)) : emax - int'($urandom_range(1, 3));
    r = (64'(e) << mw) | frac;
    r[bw-1] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic run_op(input string tag, input int bw, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_res, input logic [4:0] exp_fl, input int exp_lat,
                        input int hold);
    int lat;
    logic [63:0] r0;
    logic [4:0] f0;
    @(posedge clk); #1;
    check({tag, " in_ready"}, 64'(ir(bw)), 64'd1);
    drive(bw, 1'b1, a, b);
    @(posedge clk); #1;
    drive(bw, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
    lat = 0;
    while (!ov(bw) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " out"}, res(bw), exp_res);
    check({tag, " flags"}, 64'(flg(bw)), 64'(exp_fl));
    r0 = res(bw);
    f0 = flg(bw);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold out"}, res(bw), r0);
      check({tag, " hold flags"}, 64'(flg(bw)), 64'(f0));
      check({tag, " hold valid"}, 64'(ov(bw)), 64'd1);
      check({tag, " hold in_ready"}, 64'(ir(bw)), 64'd0);
    end
    set_ready(bw, 1'b1);
    @(posedge clk); #1;
    set_ready(bw, 1'b0);
    check({tag, " consumed valid"}, 64'(ov(bw)), 64'd0);
    check({tag, " consumed in_ready"}, 64'(ir(bw)), 64'd1);
  endtask

  initial begin
    logic [63:0] a, b, er;
    logic [4:0]  ef;
    bit sp;
    int bw;
    rst = 1'b1;
    drive(32, 1'b0, 64'b0, 64'b0);
    drive(64, 1'b0, 64'b0, 64'b0);
    set_ready(32, 1'b0);
    set_ready(64, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset out32", res(32), 64'b0);
    check("reset flags32", 64'(flg(32)), 64'b0);
    check("reset valid32", 64'(ov(32)), 64'd0);
    check("reset ready32", 64'(ir(32)), 64'd1);
    check("reset valid64", 64'(ov(64)), 64'd0);
    check("reset ready64", 64'(ir(64)), 64'd1);
    rst = 1'b0;

    run_op("six_by_two", 32, 64'h40C00000, 64'h40000000, 64'h40400000, 5'b00000, 28, 0);
    run_op("third32", 32, 64'h3F800000, 64'h40400000, 64'h3EAAAAAB, 5'b00001, 28, 0);
    run_op("third64", 64, 64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, 5'b00001, 57, 0);
    run_op("neg_div0", 32, 64'hBF800000, 64'h00000000, 64'hFF800000, 5'b01000, 1, 0);
    run_op("zero_zero", 32, 64'h00000000, 64'h80000000, 64'h7FC00000, 5'b10000, 1, 0);
    run_op("overflow", 32, 64'h7F7FFFFF, 64'h3F000000, 64'h7F800000, 5'b00101, 28, 0);
    run_op("underflow", 32, 64'h00800000, 64'h40000000, 64'h00000000, 5'b00011, 28, 0);
    run_op("backpressure", 32, 64'h3F800000, 64'h40400000, 64'h3EAAAAAB, 5'b00001, 28, 10);

    // abort an operation mid-divide
    @(posedge clk); #1;
    drive(32, 1'b1, 64'h3F800000, 64'h40400000);
    @(posedge clk); #1;
    drive(32, 1'b0, 64'b0, 64'b0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort valid", 64'(ov(32)), 64'd0);
    check("abort in_ready", 64'(ir(32)), 64'd1);
    check("abort out", res(32), 64'b0);
    #1;
    rst = 1'b0;
    run_op("ten_by_five", 32, 64'h41200000, 64'h40A00000, 64'h40000000, 5'b00000, 28, 0);

    for (int i = 0; i < 60; i++) begin
      bw = (i % 2 == 0) ? 32 : 64;
      a = gen(bw);
      b = gen(bw);
      model(bw, a, b, er, ef, sp);
      run_op($sformatf("rand%0d_%h_%h", i, a, b), bw, a, b, er, ef,
             sp ? 1 : ((bw == 32) ? 28 : 57), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
